// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debouncing; reports one hex
// code plus a single-cycle update strobe per confirmed key press.
//
// state      | meaning
// SCAN       | rotate the driven column, sample rows at the end of each dwell
// PRESS_DB   | column frozen, counting consecutive low cycles of captured row
// HELD       | key confirmed, waiting for captured row to go high
// RELEASE_DB | counting consecutive high cycles of captured row
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] value,
  output logic       update_value,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] SCAN       = 2'd0;
  localparam logic [1:0] PRESS_DB   = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] RELEASE_DB = 2'd3;

  logic [3:0]    rs_meta;
  logic [3:0]    rs;
  logic [1:0]    state;
  logic [1:0]    col;
  logic [1:0]    row;
  logic [1:0]    low_row;
  logic [SW-1:0] dwell;
  logic [DW-1:0] db_cnt;
  logic          row_level;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // The column register is frozen outside SCAN, so it doubles as the captured column.
  always_comb begin
    cols = ~(4'b0001 << col);
  end

  always_comb begin
    low_row = 2'd3;
    if (!rs[0])      low_row = 2'd0;
    else if (!rs[1]) low_row = 2'd1;
    else if (!rs[2]) low_row = 2'd2;
  end

  assign row_level = rs[row];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_meta      <= 4'hF;
      rs           <= 4'hF;
      state        <= SCAN;
      col          <= 2'd0;
      row          <= 2'd0;
      dwell        <= '0;
      db_cnt       <= '0;
      value        <= 4'h0;
      update_value <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      rs_meta      <= rows;
      rs           <= rs_meta;
      update_value <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == SCAN_LAST) begin
            dwell <= '0;
            if (rs != 4'hF) begin
              row    <= low_row;
              db_cnt <= '0;
              state  <= PRESS_DB;
            end else begin
              col <= col + 2'd1;
            end
          end else begin
            dwell <= dwell + SW'(1);
          end
        end
        PRESS_DB: begin
          if (row_level) begin
            state <= SCAN;
            col   <= col + 2'd1;
            dwell <= '0;
          end else if (db_cnt == DB_LAST) begin
            value        <= key_code(row, col);
            update_value <= 1'b1;
            key_held     <= 1'b1;
            state        <= HELD;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        HELD: begin
          if (row_level) begin
            db_cnt <= '0;
            state  <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (!row_level) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            key_held <= 1'b0;
            state    <= SCAN;
            col      <= col + 2'd1;
            dwell    <= '0;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and random keypad scenarios against a key-map reference model;
// every confirmed press is compared with the code the pressed key should give.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] value;
  logic       update_value;
  logic       key_held;

  logic [15:0] keys;
  logic        armed;
  logic [3:0]  prev_value;
  logic        last_reset;
  int          vectors;
  int          miscompares;
  logic [3:0]  got[$];
  logic [3:0]  expq[$];
  logic [3:0]  code_of[16];

  keypad_scanner #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rows        (rows),
    .cols        (cols),
    .value       (value),
    .update_value(update_value),
    .key_held    (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to a low-driven column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (armed) begin
      vectors++;
      assert ($countones(~cols) == 1) else begin
        miscompares++;
        $error("FAIL cols_onecold: observed %b expected exactly one low bit", cols);
      end
      if (update_value) begin
        got.push_back(value);
      end else if (reset && last_reset) begin
        vectors++;
        assert (value === prev_value) else begin
          miscompares++;
          $error("FAIL value_hold: observed %h expected %h", value, prev_value);
        end
      end
    end
    prev_value = value;
    last_reset = reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_codes(input string tag);
    int n;
    chk({tag, "_count"}, got.size(), expq.size());
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++) chk({tag, "_code"}, got[i], expq[i]);
    got.delete();
    expq.delete();
  endtask

  task automatic release_latency(input string tag);
    int lat;
    lat = 0;
    while (key_held === 1'b1 && lat < 40) begin
      tick(1);
      lat++;
    end
    chk({tag, "_release_lat_10to12"}, (lat >= 10 && lat <= 12), 1);
  endtask

  initial begin
    logic [3:0] exp_col;
    int idx;
    code_of = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    vectors = 0;
    miscompares = 0;
    armed = 1'b0;
    keys = '0;
    reset = 1'b0;

    tick(3);
    chk("rst_cols", cols, 4'hE);
    chk("rst_value", value, 4'h0);
    chk("rst_update", update_value, 1'b0);
    chk("rst_held", key_held, 1'b0);
    armed = 1'b1;
    reset = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      exp_col = ~(4'b0001 << ((j / 4) % 4));
      chk("rotate", cols, exp_col);
      tick(1);
    end
    check_codes("idle");

    keys = 16'b1 << 6;
    tick(200);
    expq.push_back(code_of[6]);
    chk("key6_cols_frozen", cols, 4'hB);
    chk("key6_held", key_held, 1'b1);
    check_codes("key6");
    keys = '0;
    release_latency("key6");
    chk("key6_resume_col", cols, 4'h7);
    tick(40);
    check_codes("key6_after");

    for (int i = 0; i < 16; i++) begin
      keys = 16'b1 << i;
      tick(100);
      keys = '0;
      tick(100);
      expq.push_back(code_of[i]);
    end
    check_codes("sweep");

    keys = 16'b1 << 13;
    tick(5);
    keys = '0;
    tick(3);
    chk("bounce_no_pulse", got.size(), 0);
    keys = 16'b1 << 13;
    tick(100);
    expq.push_back(4'h0);
    check_codes("bounce_press");
    keys = '0;
    tick(4);
    keys = 16'b1 << 13;
    tick(2);
    chk("bounce_still_held", key_held, 1'b1);
    keys = '0;
    release_latency("bounce");
    tick(40);
    check_codes("bounce_release");

    keys = 16'b1 << 0;
    tick(60);
    keys = keys | (16'b1 << 5);
    tick(60);
    expq.push_back(4'h1);
    check_codes("two_first");
    chk("two_held", key_held, 1'b1);
    keys = 16'b1 << 5;
    tick(100);
    expq.push_back(4'h5);
    check_codes("two_second");
    keys = '0;
    tick(60);
    check_codes("two_release");

    keys = 16'b1 << 3;
    tick(60);
    expq.push_back(4'hA);
    check_codes("pre_reset");
    chk("pre_reset_held", key_held, 1'b1);
    reset = 1'b0;
    tick(1);
    chk("midrst_cols", cols, 4'hE);
    chk("midrst_value", value, 4'h0);
    chk("midrst_update", update_value, 1'b0);
    chk("midrst_held", key_held, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(60);
    expq.push_back(4'hA);
    check_codes("after_reset");
    keys = '0;
    tick(60);
    check_codes("after_reset_release");

    for (int n = 0; n < 12; n++) begin
      idx = $urandom_range(0, 15);
      keys = 16'b1 << idx;
      tick($urandom_range(40, 80));
      keys = '0;
      tick($urandom_range(30, 60));
      expq.push_back(code_of[idx]);
    end
    check_codes("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and debounces key presses.
- Emits one 4-bit hex code plus a one-cycle `update_value` strobe for each debounced press.
- Input-side counterpart of `dual_seven_segment_display`: `value`/`update_value` connect directly to that block's `value`/`update_value` ports.
- Single-key semantics: a press is reported once; no new key is accepted until the held key is released and the release is debounced.

Parameters:
- SCAN_CYCLES, 1000, clock cycles each column is driven before its rows are sampled (settling time); minimum 3.
- DEBOUNCE_CYCLES, 50000, consecutive cycles a row level must be stable to confirm a press or a release; minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- rows  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- cols  output  4  keypad column drive, active-low, exactly one bit low at all times.
- value  output  4  hex code of the last confirmed key.
- update_value  output  1  one-cycle pulse when `value` is updated with a new press.
- key_held  output  1  high while a confirmed key is held (through release debounce).

Behaviour:
- Reset (reset==0 at posedge clk):
  - cols=4'b1110, value=4'h0, update_value=0, key_held=0.
  - State SCAN, all counters 0, row synchronizer flops = 4'b1111.
- Synchronizer: rows pass through a 2-flop synchronizer (`rs`); all decisions use `rs`.
- Key map (row r = rows bit r, column c = cols bit c):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- State SCAN:
  - Drive the current column; dwell counter counts 0..SCAN_CYCLES-1.
  - On the final dwell cycle, sample `rs`.
  - If any bit is low: capture the lowest-index low row and the current column, then go to PRESS_DB. Column drive is frozen.
  - Otherwise: rotate to the next column (1110 -> 1101 -> 1011 -> 0111 -> 1110) and restart the dwell.
- State PRESS_DB:
  - Count cycles while `rs[captured row]` is 0.
  - If it reads 1 before the count completes: go to SCAN and advance to the next column (glitch rejected, no strobe).
  - After DEBOUNCE_CYCLES consecutive low cycles: on the next edge, `value` = mapped code, update_value=1 for exactly one cycle, key_held=1, go to HELD.
- State HELD:
  - Column stays frozen; other rows and columns are ignored, so a second simultaneous key produces no output.
  - When `rs[captured row]` reads 1, go to RELEASE_DB with the counter cleared.
- State RELEASE_DB:
  - Count consecutive high cycles of `rs[captured row]`.
  - Any low sample returns to HELD with no strobe.
  - After DEBOUNCE_CYCLES consecutive high cycles: key_held=0, go to SCAN starting at the column after the captured one.
- Value persistence: `value` holds its last code indefinitely; it changes only together with an `update_value` pulse.
- Latency from the synchronized press: at most one full scan (4*SCAN_CYCLES) plus DEBOUNCE_CYCLES plus 1 to the strobe. Add 2 cycles for the synchronizer.
- Reset mid-operation: any state returns to the reset values on the next edge. A key still held is re-detected as a new press after reset deasserts.
- Counter widths: sized with $clog2 of the parameter; counters saturate/clear only as described, with no wrap-around inside a state.

Test Plan:
Bench uses SCAN_CYCLES=4, DEBOUNCE_CYCLES=8; the keypad model drives rows[r]=0 when cols[c]==0 and key (r,c) is pressed.

- Reset held low for 3 cycles, then released -> cols=1110, value=0, update_value=0, key_held=0. cols rotates every 4 cycles in the order 1110, 1101, 1011, 0111, 1110.
- Press key (r1,c2) "6" and hold for 200 cycles -> exactly one update_value pulse with value=4'h6. cols frozen at 1011; key_held=1 until 8 cycles after the synchronized release, then scanning resumes at 0111.
- Sweep all 16 keys, each pressed 100 cycles then released 100 cycles -> codes 1,2,3,A,4,5,6,B,7,8,9,C,E,0,F,D in order, 16 pulses total, 0 errors.
- Bounce: "0" (r3,c1) pressed for 5 cycles, released for 3, then held steady -> no pulse during the bounce; a single pulse with value=4'h0 after the stable period. A release bounce (high 4, low 2, high steady) -> key_held stays 1 until 8 stable high cycles, and no second pulse.
- Two keys: "1" held, then "5" pressed while "1" is held -> one pulse, value=1. After "1" is released (with "5" still held) -> a new press is detected and reports value=5.
- reset driven low during HELD with "A" still pressed -> outputs return to reset values. After release of reset -> "A" is re-detected, giving one pulse with value=4'hA.
